// File: rtl/deviation_display_mux.sv
// Multi-channel position-to-deviation converter with a stability filter and a
// time-multiplexed active-low 7-segment display bank.
module deviation_display_mux #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned POS_W     = 32,
    parameter int unsigned POS_MIN   = 228,
    parameter int unsigned POS_MAX   = 830,
    parameter int unsigned CENTER    = 544,
    parameter int unsigned STEP      = 33,
    parameter int unsigned MAX_DIGIT = 9,
    parameter int unsigned STABLE_N  = 2,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [CHANNELS*POS_W-1:0]                          pos,
    output logic [CHANNELS*4-1:0]                              digit_out,
    output logic [CHANNELS-1:0]                                pos_right,
    output logic                                               conv_done,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0]  conv_ch,
    output logic [6:0]                                         seg_n,
    output logic                                               side_n,
    output logic [CHANNELS-1:0]                                dig_sel_n
);

    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_N + 1);
    localparam int unsigned SC_W  = $clog2(SCAN_DIV);

    localparam logic [POS_W-1:0] MIN_V    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] MAX_V    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] CENTER_V = POS_W'(CENTER);
    localparam logic [POS_W:0]   STEP_V   = (POS_W + 1)'(STEP);
    localparam logic [POS_W:0]   HALF_V   = (POS_W + 1)'(STEP / 2);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {StLoad, StDiv, StCommit} state_e;

    state_e state_q, state_d;

    logic [POS_W:0]                rem_q;
    logic [3:0]                    q_q;
    logic [3:0]                    raw_q;
    logic                          raw_right_q;
    logic [CH_W-1:0]               conv_ch_q;
    logic [CHANNELS-1:0][4:0]      cand_q;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;
    logic [CHANNELS-1:0][3:0]      digit_q;
    logic [CHANNELS-1:0]           right_q;

    logic [POS_W-1:0] pos_sel;
    logic [POS_W-1:0] mag;
    logic             in_range;
    logic             div_step;
    logic [4:0]       cand_new;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_new;
    logic             commit;

    always_comb begin
        pos_sel  = pos[conv_ch_q*POS_W +: POS_W];
        in_range = (pos_sel >= MIN_V) && (pos_sel <= MAX_V);
        mag      = (pos_sel >= CENTER_V) ? (pos_sel - CENTER_V) : (CENTER_V - pos_sel);
        div_step = (rem_q >= STEP_V) && (q_q < 4'(MAX_DIGIT));
        cand_new = {raw_q, raw_right_q};
        cnt_cur  = cnt_q[conv_ch_q];
        if (cand_q[conv_ch_q] == cand_new) begin
            cnt_new = (cnt_cur >= CNT_W'(STABLE_N)) ? cnt_cur : cnt_cur + 1'b1;
        end else begin
            cnt_new = CNT_W'(1);
        end
        commit = (cnt_new == CNT_W'(STABLE_N));
    end

    // Converter FSM: state register, next state, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StLoad:   state_d = in_range ? StDiv : StCommit;
            StDiv:    if (!div_step) state_d = StCommit;
            StCommit: state_d = StLoad;
            default:  state_d = StLoad;
        endcase
    end

    always_comb begin
        conv_done = (state_q == StCommit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= '0;
            q_q         <= '0;
            raw_q       <= 4'hF;
            raw_right_q <= 1'b0;
            conv_ch_q   <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            digit_q     <= {CHANNELS{4'hF}};
            right_q     <= '0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (in_range) begin
                        rem_q       <= {1'b0, mag} + HALF_V;
                        q_q         <= '0;
                        raw_right_q <= (pos_sel >= CENTER_V);
                    end else begin
                        raw_q       <= 4'hF;
                        raw_right_q <= 1'b0;
                    end
                end
                StDiv: begin
                    if (div_step) begin
                        rem_q <= rem_q - STEP_V;
                        q_q   <= q_q + 4'd1;
                    end else begin
                        raw_q <= q_q;
                    end
                end
                StCommit: begin
                    cand_q[conv_ch_q] <= cand_new;
                    cnt_q[conv_ch_q]  <= cnt_new;
                    if (commit) begin
                        digit_q[conv_ch_q] <= raw_q;
                        right_q[conv_ch_q] <= raw_right_q;
                    end
                    conv_ch_q <= (conv_ch_q == LAST_CH) ? '0 : conv_ch_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign digit_out = digit_q;
    assign pos_right = right_q;
    assign conv_ch   = conv_ch_q;

    // Display scan, free-running and independent of the converter.
    logic [SC_W-1:0] scan_cnt_q;
    logic [CH_W-1:0] scan_ch_q;
    logic [6:0]      seg_n_q;
    logic            side_n_q;
    logic [CHANNELS-1:0] dig_sel_n_q;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h7E;
            4'd1:    seg_of = 7'h30;
            4'd2:    seg_of = 7'h6D;
            4'd3:    seg_of = 7'h79;
            4'd4:    seg_of = 7'h33;
            4'd5:    seg_of = 7'h5B;
            4'd6:    seg_of = 7'h5F;
            4'd7:    seg_of = 7'h70;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h7B;
            default: seg_of = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            scan_ch_q   <= '0;
            seg_n_q     <= 7'h7F;
            side_n_q    <= 1'b1;
            dig_sel_n_q <= ~CHANNELS'(1);
        end else begin
            if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                scan_ch_q  <= (scan_ch_q == LAST_CH) ? '0 : scan_ch_q + 1'b1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
            seg_n_q     <= ~seg_of(digit_q[scan_ch_q]);
            side_n_q    <= ~right_q[scan_ch_q];
            dig_sel_n_q <= ~(CHANNELS'(1) << scan_ch_q);
        end
    end

    assign seg_n     = seg_n_q;
    assign side_n    = side_n_q;
    assign dig_sel_n = dig_sel_n_q;

endmodule

// File: tb/tb_deviation_display_mux.sv
// Directed bench for deviation_display_mux: vector table for conversions plus
// hand sequences for stability filtering, reset during DIV and display scan.
module tb_deviation_display_mux;

    localparam int unsigned CHANNELS = 2;
    localparam int unsigned POS_W    = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS*POS_W-1:0] pos;
    logic [CHANNELS*4-1:0]     digit_out;
    logic [CHANNELS-1:0]       pos_right;
    logic                      conv_done;
    logic [0:0]                conv_ch;
    logic [6:0]                seg_n;
    logic                      side_n;
    logic [CHANNELS-1:0]       dig_sel_n;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    deviation_display_mux #(
        .CHANNELS (2),
        .POS_W    (32),
        .POS_MIN  (228),
        .POS_MAX  (830),
        .CENTER   (544),
        .STEP     (33),
        .MAX_DIGIT(9),
        .STABLE_N (2),
        .SCAN_DIV (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pos      (pos),
        .digit_out(digit_out),
        .pos_right(pos_right),
        .conv_done(conv_done),
        .conv_ch  (conv_ch),
        .seg_n    (seg_n),
        .side_n   (side_n),
        .dig_sel_n(dig_sel_n)
    );

    typedef struct {
        int         p;
        logic [3:0] dig;
        logic       right;
        int         interval;
        logic [6:0] seg;
        logic       side;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pos(input int p0, input int p1);
        pos[0 +: POS_W]     = POS_W'(p0);
        pos[POS_W +: POS_W] = POS_W'(p1);
    endtask

    // Returns at the negedge where conv_done is seen; cycles = clocks waited.
    task automatic next_conv(output int ch, output int cycles);
        cycles = 0;
        ch = -1;
        do begin
            @(negedge clk);
            cycles++;
        end while (conv_done !== 1'b1 && cycles < 50);
        if (conv_done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL conv_done timeout: got no pulse, expected one within 50 cycles");
        end else begin
            ch = int'(conv_ch);
        end
    endtask

    task automatic ch0_conv(input int val);
        int ch, cyc;
        ch = -1;
        for (int g = 0; g < 4 && ch != 1; g++) next_conv(ch, cyc);
        pos[0 +: POS_W] = POS_W'(val);
        next_conv(ch, cyc);
        check("alt conv_ch", ch, 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " digit_out"}, digit_out, 8'hFF);
        check({tag, " pos_right"}, pos_right, 2'b00);
        check({tag, " conv_done"}, conv_done, 1'b0);
        check({tag, " conv_ch"}, conv_ch, 1'b0);
        check({tag, " seg_n"}, seg_n, 7'h7F);
        check({tag, " side_n"}, side_n, 1'b1);
        check({tag, " dig_sel_n"}, dig_sel_n, 2'b10);
    endtask

    initial begin
        vec_t       vecs[10];
        int         ch, cyc;
        logic [7:0] exp_dig[4];
        int         exp_ch[4];

        vecs[0] = '{544, 4'h0, 1'b1, 3,  7'h01, 1'b0};
        vecs[1] = '{561, 4'h1, 1'b1, 4,  7'h4F, 1'b0};
        vecs[2] = '{560, 4'h0, 1'b1, 3,  7'h01, 1'b0};
        vecs[3] = '{263, 4'h9, 1'b0, 12, 7'h04, 1'b1};
        vecs[4] = '{830, 4'h9, 1'b1, 12, 7'h04, 1'b0};
        vecs[5] = '{228, 4'h9, 1'b0, 12, 7'h04, 1'b1};
        vecs[6] = '{227, 4'hF, 1'b0, 2,  7'h7F, 1'b1};
        vecs[7] = '{831, 4'hF, 1'b0, 2,  7'h7F, 1'b1};
        vecs[8] = '{600, 4'h2, 1'b1, 5,  7'h12, 1'b0};
        vecs[9] = '{480, 4'h2, 1'b0, 5,  7'h12, 1'b1};
        exp_dig = '{8'hFF, 8'hFF, 8'hF0, 8'h10};
        exp_ch  = '{0, 1, 0, 1};

        rst = 1'b1;
        set_pos(544, 561);
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;

        // Commits land on the second matching COMMIT of each channel.
        for (int k = 0; k < 4; k++) begin
            next_conv(ch, cyc);
            check($sformatf("stab conv_ch %0d", k), ch, exp_ch[k]);
            @(negedge clk);
            check($sformatf("stab digit_out %0d", k), digit_out, exp_dig[k]);
        end
        check("stab pos_right", pos_right, 2'b11);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dig_sel_n == 2'b10) begin
                check("scan seg ch0", seg_n, 7'h01);
            end else begin
                check("scan dig_sel_n", dig_sel_n, 2'b01);
                check("scan seg ch1", seg_n, 7'h4F);
            end
            check("scan side_n", side_n, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            next_conv(ch, cyc);
            set_pos(vecs[i].p, vecs[i].p);
            for (int k = 0; k < 4; k++) next_conv(ch, cyc);
            check($sformatf("v%0d pos=%0d interval", i, vecs[i].p), cyc, vecs[i].interval);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("v%0d pos=%0d digit_out", i, vecs[i].p), digit_out,
                  {vecs[i].dig, vecs[i].dig});
            check($sformatf("v%0d pos=%0d pos_right", i, vecs[i].p), pos_right,
                  {vecs[i].right, vecs[i].right});
            check($sformatf("v%0d pos=%0d seg_n", i, vecs[i].p), seg_n, vecs[i].seg);
            check($sformatf("v%0d pos=%0d side_n", i, vecs[i].p), side_n, vecs[i].side);
        end

        // Alternating input never stabilises; holding it then commits.
        next_conv(ch, cyc);
        set_pos(544, 544);
        for (int k = 0; k < 4; k++) next_conv(ch, cyc);
        for (int k = 0; k < 6; k++) begin
            ch0_conv((k % 2 == 0) ? 600 : 544);
            check($sformatf("alt hold %0d", k), digit_out, 8'h00);
        end
        ch0_conv(600);
        check("hold first", digit_out, 8'h00);
        ch0_conv(600);
        check("hold commit digit", digit_out, 8'h02);
        check("hold commit right", pos_right, 2'b11);

        // Reset in the middle of a long DIV.
        next_conv(ch, cyc);
        set_pos(263, 263);
        next_conv(ch, cyc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("div rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst conv_done", conv_done, 1'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("post rst dig_sel_n %0d", k), dig_sel_n,
                  (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("post rst conv_done %0d", k), conv_done, (k == 11) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        check("post rst digit_out", digit_out, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/deviation_display_mux.md
Name: deviation_display_mux

Overview:
Multi-channel successor to the single-axis position-to-digit display decoder. It converts each channel's position value into a 0–9 deviation magnitude from a programmable centre, plus a side flag. Conversion uses a sequential divider, round-robin across channels, with a stability filter before results are committed. Committed digits drive a time-multiplexed, active-low 7-segment display bank. The block sits between the position-tracking logic and the board's seven-segment/LED pins.

Parameters:
CHANNELS, 2, number of position channels and display digits (1–8)
POS_W, 32, width of each position input
POS_MIN, 228, lowest in-range position
POS_MAX, 830, highest in-range position
CENTER, 544, position mapped to deviation 0
STEP, 33, position units per digit step
MAX_DIGIT, 9, saturation value of the deviation digit (≤9)
STABLE_N, 2, identical consecutive conversions required before commit (≥1)
SCAN_DIV, 50000, clocks each display digit stays enabled (≥2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pos  in  CHANNELS*POS_W  channel k occupies bits [k*POS_W +: POS_W], unsigned
digit_out  out  CHANNELS*4  committed digit per channel; 4'hF = out of range
pos_right  out  CHANNELS  committed side flag: 1 when in range and pos ≥ CENTER
conv_done  out  1  one-cycle pulse at the end of each conversion
conv_ch  out  $clog2(CHANNELS) (min 1)  channel of the current or just-finished conversion
seg_n  out  7  segments {a,b,c,d,e,f,g}, active-low
side_n  out  1  side LED for the scanned channel, active-low (lit when pos_right = 1)
dig_sel_n  out  CHANNELS  one-hot digit enable, active-low

Behaviour:
- Reset values (asynchronous): digit_out all 4'hF; pos_right 0; conv_done 0; conv_ch 0; seg_n 7'h7F; side_n 1; dig_sel_n = all ones except bit 0 = 0. Converter FSM goes to LOAD. Stability counters and candidates are cleared. Scan counter = 0. Reset during DIV abandons that conversion; no commit occurs.
- Converter FSM (no idle state):
  - LOAD (1 cycle): sample pos[conv_ch].
    - If pos < POS_MIN or pos > POS_MAX: raw = 4'hF, raw_right = 0, next state COMMIT.
    - Otherwise: mag = |pos − CENTER| (POS_W bits, no wrap); rem = mag + STEP/2 (POS_W+1 bits); q = 0; raw_right = (pos ≥ CENTER); next state DIV.
  - DIV (one iteration per cycle):
    - If rem ≥ STEP and q < MAX_DIGIT: rem −= STEP, q += 1, stay in DIV.
    - Otherwise: raw = q, next state COMMIT.
    - DIV therefore lasts q+1 cycles, maximum MAX_DIGIT+1. Result = min(MAX_DIGIT, floor((mag + STEP/2) / STEP)).
  - COMMIT (1 cycle): conv_done = 1.
    - If {raw, raw_right} equals the stored candidate for the channel: increment its count, saturating at STABLE_N.
    - Otherwise: candidate = {raw, raw_right}, count = 1.
    - When count reaches STABLE_N, digit_out and pos_right for the channel are updated; they become visible the cycle after COMMIT.
    - conv_ch then advances, wrapping from CHANNELS−1 to 0; next state LOAD.
  - With STABLE_N = 1, every conversion commits.
- Display scan:
  - The scan counter runs 0..SCAN_DIV−1. At the terminal count, scan_ch advances, wrapping to 0.
  - seg_n, side_n and dig_sel_n are registered from scan_ch and the committed values, giving 1-cycle latency. They are independent of the converter.
- Segment map (active-high abcdefg, then inverted for seg_n): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B. Any other code gives seg_n = 7'h7F (blank).
- Out of range: seg_n blank and side_n = 1.
- pos may change at any time. Only the LOAD sample is used.

Test Plan:
1. Assert rst mid-run, including during DIV -> all outputs at reset values; digit_out = 8'hFF (CHANNELS=2); dig_sel_n = 2'b10; no conv_done until after release.
2. Hold ch0 = 544 and ch1 = 561 for 4 conversions -> ch0 commits digit 0, pos_right 1; ch1 commits digit 1, pos_right 1. Commits occur on the second COMMIT per channel. seg_n = 7'h01 while ch0 is scanned and 7'h4F while ch1 is scanned.
3. Boundary values -> pos = 560 gives 0 (DIV = 1 cycle); pos = 263 gives 9 with pos_right 0 (DIV = 10 cycles); pos = 830 gives 9 with pos_right 1; pos = 228 gives 9.
4. pos = 227 and pos = 831 -> digit 4'hF, pos_right 0, seg_n 7'h7F, side_n 1; LOAD goes straight to COMMIT.
5. ch0 alternating 544/600 on every conversion (STABLE_N = 2) -> digit_out for ch0 never changes from its previous committed value. Holding 600 then commits 2 after two conversions.
6. SCAN_DIV = 4 -> dig_sel_n cycles 10, 01, 10, … every 4 clocks; seg_n follows the scanned digit one cycle after each switch.
